// File: rtl/spu_mux_pkg.sv
// Shared types and helpers for the SPU operand selector family.
// sel_word works on a bus padded to MAX_NUM_IN slots of MAX_WIDTH bits.
package spu_mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int unsigned MAX_NUM_IN = 16;
  localparam int unsigned MAX_WIDTH  = 256;
  localparam int unsigned MAX_SEL_W  = 5;

  typedef logic [MAX_NUM_IN*MAX_WIDTH-1:0] bus_t;
  typedef logic [MAX_WIDTH-1:0]            word_t;

  function automatic logic num_in_ok(input int n);
    return (n >= 2);
  endfunction

  // Out-of-range selects fall through every compare and return zero.
  function automatic word_t sel_word(input bus_t data,
                                     input logic [MAX_SEL_W-1:0] sel,
                                     input int unsigned num_in);
    word_t w;
    w = '0;
    for (int unsigned k = 0; k < MAX_NUM_IN; k++) begin
      if ((k < num_in) && (32'(sel) == k)) begin
        w = data[k*MAX_WIDTH +: MAX_WIDTH];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/mux_n_to_1_comb.sv
// Combinational N-to-1 word selector with out-of-range select detect.
module mux_n_to_1_comb
  import spu_mux_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word,
  output logic                    err
);

  if ((WIDTH > int'(MAX_WIDTH)) || (NUM_IN > int'(MAX_NUM_IN))) begin : g_size_chk
    $error("mux_n_to_1_comb: WIDTH or NUM_IN exceeds package limits");
  end

  bus_t bus_s;

  // Re-pack the candidates onto the package's fixed slot stride.
  always_comb begin
    bus_s = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      bus_s[k*MAX_WIDTH +: WIDTH] = data[k*WIDTH +: WIDTH];
    end
  end

  assign word = WIDTH'(sel_word(bus_s, MAX_SEL_W'(sel), NUM_IN));
  assign err  = (32'(sel) >= NUM_IN);

endmodule

// File: rtl/mux_n_to_1_skid.sv
// Registered N-to-1 word selector with a 2-entry skid buffer on a
// valid/ready stream and a sticky out-of-range select flag.
module mux_n_to_1_skid
  import spu_mux_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  if (!num_in_ok(NUM_IN)) begin : g_num_in_chk
    $error("mux_n_to_1_skid: NUM_IN must be at least 2");
  end

  skid_state_t      state_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             out_valid_r;
  logic             not_full_r;
  logic             sel_err_r;
  logic [WIDTH-1:0] word_s;
  logic             range_err_s;
  logic             accept_s;
  logic             drain_s;

  mux_n_to_1_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .data (in_data),
    .sel  (in_sel),
    .word (word_s),
    .err  (range_err_s)
  );

  // in_ready comes from state only, so out_ready never reaches it combinationally.
  assign in_ready  = not_full_r & ~reset;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign sel_err   = sel_err_r;
  assign accept_s  = in_valid & in_ready;
  assign drain_s   = out_valid_r & out_ready;

  // Skid FSM: main register feeds the output, skid holds the second word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= EMPTY;
      main_r      <= '0;
      skid_r      <= '0;
      out_valid_r <= 1'b0;
      not_full_r  <= 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_r      <= word_s;
            state_r     <= ONE;
            out_valid_r <= 1'b1;
          end
        end
        ONE: begin
          if (accept_s && !drain_s) begin
            skid_r     <= word_s;
            state_r    <= FULL;
            not_full_r <= 1'b0;
          end else if (accept_s) begin
            main_r <= word_s;
          end else if (drain_s) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (drain_s) begin
            main_r     <= skid_r;
            state_r    <= ONE;
            not_full_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
          not_full_r  <= 1'b1;
        end
      endcase
    end
  end

  // Sticky select error: a new illegal accept beats a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err_r <= 1'b0;
    end else if (accept_s && range_err_s) begin
      sel_err_r <= 1'b1;
    end else if (err_clr) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= sel_err_r;
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_skid.sv
// Bench for mux_n_to_1_skid: directed vector table on the default build,
// then randomized streams on NUM_IN=2/5/8, WIDTH=32 against a queue model.
module tb_mux_n_to_1_skid;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit start_rand = 1'b0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- default build: WIDTH=128, NUM_IN=3 ----------------
  logic [383:0] d0;
  logic [1:0]   s0;
  logic         v0, ir0, ov0, or0, err0, clr0;
  logic [127:0] od0;

  mux_n_to_1_skid #(.WIDTH(128), .NUM_IN(3)) u_dut0 (
    .clk(clk), .reset(reset), .in_data(d0), .in_sel(s0), .in_valid(v0),
    .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(or0),
    .sel_err(err0), .err_clr(clr0)
  );

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic       rdy;
    logic       clr;
    logic       ov;
    logic       ir;
    logic [1:0] didx;
    logic       err;
  } vec_t;

  vec_t         tbl[18];
  logic [127:0] words[4];

  initial begin
    words[0] = '0;
    words[1] = {16{8'h11}};
    words[2] = {16{8'h22}};
    words[3] = {16{8'h33}};
    d0  = {words[3], words[2], words[1]};
    s0  = 2'd0; v0 = 1'b0; or0 = 1'b0; clr0 = 1'b0;
    //         v     sel   rdy   clr     ov    ir    didx  err
    tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0,  1'b1, 1'b1, 2'd1, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b0,  1'b1, 1'b1, 2'd2, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b0,  1'b1, 1'b1, 2'd3, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 1'b0,  1'b0, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 1'b0,  1'b1, 1'b1, 2'd1, 1'b0};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 1'b0,  1'b1, 1'b0, 2'd1, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 1'b0,  1'b1, 1'b0, 2'd1, 1'b0};
    tbl[7]  = '{1'b1, 2'd2, 1'b1, 1'b0,  1'b1, 1'b1, 2'd2, 1'b0};
    tbl[8]  = '{1'b1, 2'd2, 1'b1, 1'b0,  1'b1, 1'b1, 2'd3, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 1'b1, 1'b0,  1'b0, 1'b1, 2'd0, 1'b0};
    tbl[10] = '{1'b1, 2'd3, 1'b1, 1'b0,  1'b1, 1'b1, 2'd0, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 1'b1, 1'b0,  1'b0, 1'b1, 2'd0, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 1'b1, 1'b1,  1'b0, 1'b1, 2'd0, 1'b0};
    tbl[13] = '{1'b1, 2'd3, 1'b1, 1'b0,  1'b1, 1'b1, 2'd0, 1'b1};
    tbl[14] = '{1'b1, 2'd3, 1'b1, 1'b1,  1'b1, 1'b1, 2'd0, 1'b1};
    tbl[15] = '{1'b0, 2'd0, 1'b1, 1'b1,  1'b0, 1'b1, 2'd0, 1'b0};
    tbl[16] = '{1'b1, 2'd1, 1'b0, 1'b0,  1'b1, 1'b1, 2'd2, 1'b0};
    tbl[17] = '{1'b1, 2'd2, 1'b0, 1'b0,  1'b1, 1'b0, 2'd2, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(ov0), 128'd0);
    chk("rst_in_ready", 128'(ir0), 128'd0);
    chk("rst_out_data", od0, 128'd0);
    chk("rst_sel_err", 128'(err0), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 128'(ir0), 128'd1);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      v0 = tbl[i].v; s0 = tbl[i].sel; or0 = tbl[i].rdy; clr0 = tbl[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_out_valid", i), 128'(ov0), 128'(tbl[i].ov));
      chk($sformatf("row%0d_in_ready", i), 128'(ir0), 128'(tbl[i].ir));
      chk($sformatf("row%0d_sel_err", i), 128'(err0), 128'(tbl[i].err));
      if (tbl[i].ov) chk($sformatf("row%0d_out_data", i), od0, words[tbl[i].didx]);
    end

    // Block is FULL here: async reset mid-cycle must clear everything at once.
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(ov0), 128'd0);
    chk("midrst_in_ready", 128'(ir0), 128'd0);
    chk("midrst_out_data", od0, 128'd0);
    @(negedge clk);
    reset = 1'b0; v0 = 1'b1; s0 = 2'd0; or0 = 1'b1; clr0 = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 128'(ov0), 128'd1);
    chk("post_rst_data", od0, words[1]);
    @(negedge clk);
    v0 = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_no_stale", 128'(ov0), 128'd0);

    start_rand = 1'b1;
    for (int c = 0; c < 40000 && done_cnt < 3; c++) @(posedge clk);
    chk("sweep_all_done", 128'(done_cnt), 128'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- parameter sweep: WIDTH=32, NUM_IN=2/5/8 ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int NI = (g == 0) ? 2 : ((g == 1) ? 5 : 8);
    localparam int SW = $clog2(NI);

    logic [NI*32-1:0] d;
    logic [SW-1:0]    s;
    logic             v, ir, ov, ordy, err, clr;
    logic [31:0]      od;

    mux_n_to_1_skid #(.WIDTH(32), .NUM_IN(NI)) u_dut (
      .clk(clk), .reset(reset), .in_data(d), .in_sel(s), .in_valid(v),
      .in_ready(ir), .out_data(od), .out_valid(ov), .out_ready(ordy),
      .sel_err(err), .err_clr(clr)
    );

    initial begin
      logic [31:0] q[$];
      logic [31:0] w;
      bit          exp_err;
      bit          acc, drn, bad;
      int          drained;
      int          cycles;
      string       tag;
      tag = $sformatf("n%0d", NI);
      d = '0; s = '0; v = 1'b0; ordy = 1'b0; clr = 1'b0;
      exp_err = 1'b0; drained = 0; cycles = 0;
      wait (start_rand);
      while (drained < 3400 && cycles < 20000) begin
        @(negedge clk);
        cycles++;
        chk({tag, "_out_valid"}, 128'(ov), 128'(q.size() != 0));
        chk({tag, "_in_ready"}, 128'(ir), 128'(q.size() < 2));
        chk({tag, "_sel_err"}, 128'(err), 128'(exp_err));
        if (q.size() != 0) chk({tag, "_out_data"}, 128'(od), 128'(q[0]));
        v    = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 2) != 0);
        clr  = ($urandom_range(0, 15) == 0);
        for (int k = 0; k < NI; k++) d[k*32 +: 32] = $urandom;
        s = SW'($urandom_range(0, (1 << SW) - 1));
        bad = (int'(s) >= NI);
        w = 32'd0;
        if (!bad) w = d[int'(s)*32 +: 32];
        acc = v && (q.size() < 2);
        drn = (q.size() != 0) && ordy;
        @(posedge clk);
        if (drn) begin
          void'(q.pop_front());
          drained++;
        end
        if (acc) q.push_back(w);
        if (acc && bad) exp_err = 1'b1;
        else if (clr)   exp_err = 1'b0;
      end
      chk({tag, "_drained"}, 128'(drained >= 3400), 128'd1);
      v = 1'b0; ordy = 1'b0; clr = 1'b0;
      done_cnt++;
    end
  end

endmodule

// File: doc/mux_n_to_1_skid.md
# mux_n_to_1_skid

Parametrised, pipelined N-to-1 word selector for the SPU datapath: the registered successor to the fixed 3-to-1 128-bit operand mux. Each accepted transfer carries all candidate words plus a select index. The selected word is registered and presented downstream under a valid/ready handshake. A 2-entry skid buffer sustains one transfer per cycle through downstream stalls, and a sticky flag reports out-of-range selects.

## Interface
- `WIDTH`, default 128: word width in bits.
- `NUM_IN`, default 3: number of candidate inputs; must be ≥2.
- `SEL_W`, default `$clog2(NUM_IN)`: select width (derived; do not override).
---
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_data`  in  NUM_IN*WIDTH: packed candidates; word k is `in_data[k*WIDTH +: WIDTH]`.
- `in_sel`  in  SEL_W: index of the word to forward.
- `in_valid`  in  1: upstream offers a transfer.
- `in_ready`  out  1: block can accept a transfer.
- `out_data`  out  WIDTH: selected word.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: downstream accepts.
- `sel_err`  out  1: sticky; an accepted transfer had `in_sel` ≥ NUM_IN.
- `err_clr`  in  1: synchronous clear of `sel_err`.

## Operation
- Accept occurs when `in_valid && in_ready`. Drain occurs when `out_valid && out_ready`.
- Selected word is word `in_sel`. If `in_sel` ≥ NUM_IN, the word is all-zero and `sel_err` is set on that edge.
- Storage: a main register, which drives `out_data`, and a skid register. Order is strict FIFO.
- State machine:
  - EMPTY: accept → ONE (word loaded into the main register).
  - ONE: accept without drain → FULL (word into skid). Drain without accept → EMPTY. Accept and drain together → ONE (new word into main).
  - FULL: drain → ONE (skid moves to main). Accept is impossible because `in_ready`=0.
- `in_ready` = (state ≠ FULL) and not `reset`. It depends only on state, with no combinational path from `out_ready`.
- `out_valid` = (state ≠ EMPTY).
- `sel_err`: set wins over `err_clr` when both occur on the same edge. Otherwise `err_clr` clears it. Otherwise it holds.
- Reset values: state EMPTY, `out_valid`=0, `out_data`=0, skid contents=0, `sel_err`=0, `in_ready`=0 while `reset` is high. Reset mid-transfer discards all buffered words. No output is produced for them.

## Timing
- Latency: accept at edge n → `out_valid`=1 with the word from cycle n+1.
- Throughput: 1 word/cycle while `out_ready`=1.
- `out_data` is stable while `out_valid && !out_ready`.
- Once `out_valid` is asserted, it is not withdrawn until a drain occurs.
- `in_ready` falls on the edge the block enters FULL. It rises on the edge a word is drained from FULL.
- Upstream may change `in_data`/`in_sel` freely while `in_ready`=0. Those values are ignored.

## Structure
- Package `spu_mux_pkg`:
  - `typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t`.
  - Helper function `sel_word(data, sel)` returning the zero-filled selected word.
  - Elaboration check that NUM_IN ≥ 2.
- Sub-module `mux_n_to_1_comb` (WIDTH, NUM_IN): purely combinational selector with out-of-range detect. The top level instantiates it once, on the input side only. Skid control lives in `mux_n_to_1_skid`.

## Test plan
- Reset then stream: WIDTH=128, NUM_IN=3, words A/B/C = 0x11…1/0x22…2/0x33…3, `in_sel` cycling 0,1,2, `out_ready`=1 → outputs A,B,C on consecutive cycles one cycle after each accept; `in_ready` stays 1.
- Backpressure: `out_ready`=0 with 3 offered transfers → first two accepted, `in_ready`=0 from the second edge, `out_data` holds the first word. Raise `out_ready` → both words emerge in order; the third is accepted one cycle after the first drain.
- Illegal select: `in_sel`=3 with NUM_IN=3 → output word 0, `sel_err`=1 from the next edge, held until `err_clr`. `err_clr` coincident with a second illegal accept → `sel_err` stays 1.
- Reset mid-operation: state FULL, assert `reset` asynchronously → `out_valid`=0, `in_ready`=0, `out_data`=0 immediately. After release, the first new accept emerges with no stale data.
- Parameter sweep: NUM_IN=2, 5, 8 and WIDTH=32 with random valid/ready and sel → scoreboard matches an ordered reference model; no loss, duplication, or reordering over 10k transfers.
